// File: rtl/data_memory.sv
// Word-organised data memory with a programmable wait-state counter.
// Requests are captured, held for LATENCY cycles, then completed with a one-cycle ready/err pulse.
module data_memory #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mreq,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        ready,
   output logic        err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        write_q, write_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;

   logic [31:0] mem [DEPTH];

   logic          doAccess;
   logic [31:0]   accAddr;
   logic [31:0]   accWdata;
   logic          accWrite;
   logic          accBad;
   logic [AW-1:0] accIdx;
   logic          memWe;

   // With zero wait states the access completes on the accepting edge,
   // so it must use the live inputs rather than the (not yet loaded) captured copy.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      doAccess = 1'b0;
      accAddr  = addr_q;
      accWrite = write_q;
      accWdata = wdata_q;

      case (state_q)
         IDLE: begin
            if (mreq) begin
               addr_d  = addr;
               write_d = write;
               wdata_d = wr_data;
               cnt_d   = 4'(LATENCY);
               if (LATENCY == 0) begin
                  state_d  = RESP;
                  doAccess = 1'b1;
                  accAddr  = addr;
                  accWrite = write;
                  accWdata = wr_data;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd1) begin
               state_d  = RESP;
               cnt_d    = 4'd0;
               doAccess = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      accBad = (accAddr[1:0] != 2'b00) || ({2'b00, accAddr[31:2]} >= 32'(DEPTH));
      accIdx = accAddr[2 +: AW];

      ready_d   = doAccess;
      err_d     = doAccess && accBad;
      memWe     = doAccess && accWrite && !accBad;
      rd_data_d = rd_data_q;
      if (doAccess && !accWrite) begin
         rd_data_d = accBad ? 32'd0 : mem[accIdx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         addr_q    <= 32'd0;
         write_q   <= 1'b0;
         wdata_q   <= 32'd0;
         rd_data_q <= 32'd0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         rd_data_q <= rd_data_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
      end
   end

   // The array is deliberately left out of reset so its contents survive it.
   always_ff @(posedge clk) begin
      if (memWe) begin
         mem[accIdx] <= accWdata;
      end
   end

   assign rd_data = rd_data_q;
   assign ready   = ready_q;
   assign err     = err_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: one instance with two wait states, one with none.
// Drivers queue hand-computed responses; per-instance monitors compare on each ready pulse.
module tb_data_memory;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        mreqA, writeA, readyA, errA;
   logic [31:0] addrA, wdA, rdA;
   logic        mreqB, writeB, readyB, errB;
   logic [31:0] addrB, wdB, rdB;

   data_memory #(.DEPTH(1024), .LATENCY(2)) dutA (
      .clk(clk), .rst_n(rst_n), .mreq(mreqA), .write(writeA), .addr(addrA),
      .wr_data(wdA), .rd_data(rdA), .ready(readyA), .err(errA)
   );

   data_memory #(.DEPTH(1024), .LATENCY(0)) dutB (
      .clk(clk), .rst_n(rst_n), .mreq(mreqB), .write(writeB), .addr(addrB),
      .wr_data(wdB), .rd_data(rdB), .ready(readyB), .err(errB)
   );

   always #5 clk = ~clk;

   // Edge counter: at the falling edge after rising edge k it reads k.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [31:0] rd;
      logic        err;
   } exp_t;

   exp_t qA[$];
   exp_t qB[$];
   int   passCount  = 0;
   int   totalCount = 0;
   bit   heldA = 1'b0;
   bit   heldB = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Issues one request at a falling edge and holds mreq until ready. With keep=1 mreq
   // stays high into the next call; scramble corrupts the inputs right after acceptance.
   task automatic applyStimulus(input bit unitB, input bit w, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] expRd,
                                input bit expErr, input bit keep, input bit scramble);
      int   e0;
      int   lat;
      bit   held;
      bit   seen;
      exp_t e;
      held  = unitB ? heldB : heldA;
      lat   = unitB ? 0 : 2;
      e0    = cyc + (held ? 2 : 1);
      e.cyc = e0 + lat;
      e.rd  = expRd;
      e.err = expErr;
      if (unitB) begin
         qB.push_back(e);
         mreqB = 1'b1; writeB = w; addrB = a; wdB = d;
      end else begin
         qA.push_back(e);
         mreqA = 1'b1; writeA = w; addrA = a; wdA = d;
      end
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (scramble && !unitB && cyc == e0) begin
            addrA = ~a; wdA = ~d; writeA = ~w;
         end
         seen = unitB ? readyB : readyA;
      end
      if (!seen) begin
         totalCount++;
         $display("[TB] FAIL %s_timeout: got no ready expected ready at cycle %0d",
                  unitB ? "B" : "A", e.cyc);
      end
      if (keep) begin
         if (unitB) heldB = 1'b1; else heldA = 1'b1;
      end else begin
         if (unitB) begin mreqB = 1'b0; heldB = 1'b0; end
         else begin mreqA = 1'b0; heldA = 1'b0; end
         @(negedge clk);
      end
   endtask

   // Monitors: every ready pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (readyA) begin
         if (qA.size() == 0) begin
            totalCount++;
            $display("[TB] FAIL A_extra_ready: got ready at cycle %0d expected none", cyc);
         end else begin
            e = qA.pop_front();
            checkOutput("A_ready_cycle", 32'(cyc), 32'(e.cyc));
            checkOutput("A_err", {31'd0, errA}, {31'd0, e.err});
            checkOutput("A_rd_data", rdA, e.rd);
         end
      end else if (errA) begin
         totalCount++;
         $display("[TB] FAIL A_err_without_ready: got err=1 expected err=0 at cycle %0d", cyc);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (readyB) begin
         if (qB.size() == 0) begin
            totalCount++;
            $display("[TB] FAIL B_extra_ready: got ready at cycle %0d expected none", cyc);
         end else begin
            e = qB.pop_front();
            checkOutput("B_ready_cycle", 32'(cyc), 32'(e.cyc));
            checkOutput("B_err", {31'd0, errB}, {31'd0, e.err});
            checkOutput("B_rd_data", rdB, e.rd);
         end
      end else if (errB) begin
         totalCount++;
         $display("[TB] FAIL B_err_without_ready: got err=1 expected err=0 at cycle %0d", cyc);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      mreqA = 1'b0; writeA = 1'b0; addrA = 32'd0; wdA = 32'd0;
      mreqB = 1'b0; writeB = 1'b0; addrB = 32'd0; wdB = 32'd0;
      #2;
      checkOutput("reset_A_ready", {31'd0, readyA}, 32'd0);
      checkOutput("reset_A_err", {31'd0, errA}, 32'd0);
      checkOutput("reset_A_rd_data", rdA, 32'd0);
      checkOutput("reset_B_ready", {31'd0, readyB}, 32'd0);
      checkOutput("reset_B_err", {31'd0, errB}, 32'd0);
      checkOutput("reset_B_rd_data", rdB, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] basic write/read, two wait states");
      applyStimulus(0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 0);
      applyStimulus(0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 0);

      $display("[TB] misaligned accesses");
      applyStimulus(0, 1, 32'h4, 32'h11112222, 32'hDEADBEEF, 0, 0, 0);
      applyStimulus(0, 0, 32'h6, 32'h0, 32'h0, 1, 0, 0);
      applyStimulus(0, 1, 32'h6, 32'h0000AAAA, 32'h0, 1, 0, 0);
      applyStimulus(0, 0, 32'h4, 32'h0, 32'h11112222, 0, 0, 0);

      $display("[TB] out-of-range and last-word accesses");
      applyStimulus(0, 1, 32'h0, 32'hCAFEF00D, 32'h11112222, 0, 0, 0);
      applyStimulus(0, 1, 32'h1000, 32'hBAD0BAD0, 32'h11112222, 1, 0, 0);
      applyStimulus(0, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0, 0, 0);
      applyStimulus(0, 1, 32'hFFC, 32'h0BADC0DE, 32'hCAFEF00D, 0, 0, 0);
      applyStimulus(0, 0, 32'hFFC, 32'h0, 32'h0BADC0DE, 0, 0, 0);

      $display("[TB] zero wait states, back-to-back");
      applyStimulus(1, 1, 32'h0, 32'h12345678, 32'h0, 0, 1, 0);
      applyStimulus(1, 0, 32'h0, 32'h0, 32'h12345678, 0, 1, 0);
      applyStimulus(1, 0, 32'h0, 32'h0, 32'h12345678, 0, 0, 0);
      applyStimulus(1, 0, 32'h2, 32'h0, 32'h0, 1, 0, 0);

      $display("[TB] inputs changed while waiting, mreq held high");
      applyStimulus(0, 1, 32'h30, 32'h600D600D, 32'h0BADC0DE, 0, 1, 1);
      applyStimulus(0, 0, 32'h30, 32'h0, 32'h600D600D, 0, 1, 1);
      applyStimulus(0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 1);

      $display("[TB] reset during a pending write");
      applyStimulus(0, 1, 32'h20, 32'h77, 32'hDEADBEEF, 0, 0, 0);
      applyStimulus(0, 0, 32'h20, 32'h0, 32'h77, 0, 0, 0);
      mreqA = 1'b1; writeA = 1'b1; addrA = 32'h20; wdA = 32'h55;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_A_ready", {31'd0, readyA}, 32'd0);
      checkOutput("midreset_A_err", {31'd0, errA}, 32'd0);
      checkOutput("midreset_A_rd_data", rdA, 32'd0);
      mreqA = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(0, 0, 32'h20, 32'h0, 32'h77, 0, 0, 0);

      repeat (4) @(negedge clk);
      checkOutput("A_pending_at_end", 32'(qA.size()), 32'd0);
      checkOutput("B_pending_at_end", 32'(qB.size()), 32'd0);
      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
